clock_display_scan: RTL and testbench

- Display stage that sits directly downstream of the digital clock counters.
- Takes the binary hour/minute/second counts (7 bits each) and drives a 6-digit multiplexed seven-segment display through an 11-bit tube bus: bits 10:8 are the digit select, bits 7:0 are the segments.
- Snapshots the counts once per scan frame so the display never tears.
- Blinks the hour and minute digits while manual time-set is active.

---
 rtl/clock_disp_pkg.sv | 53 +++++
 rtl/seg7_decode.sv | 25 ++
 rtl/clock_display_scan.sv | 104 ++++++++++
 tb/tb_clock_display_scan.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display: digit positions, segment codes and the snapshot record.
// Pure definitions; no latency or flow control involved.
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] IDX_HOUR_T = 3'd0;
  localparam logic [2:0] IDX_HOUR_U = 3'd1;
  localparam logic [2:0] IDX_MIN_T  = 3'd2;
  localparam logic [2:0] IDX_MIN_U  = 3'd3;
  localparam logic [2:0] IDX_SEC_T  = 3'd4;
  localparam logic [2:0] IDX_SEC_U  = 3'd5;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int DP_BIT = 7;

  typedef struct packed {
    logic       set;
    logic [6:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } snap_t;

  function automatic logic [7:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Binary 0..127 to two seven-segment codes (tens, units); values over 99 show a dash on both.
// Purely combinational, zero latency, no flow control.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [6:0] bin_i,
  output logic [7:0] tens_seg,
  output logic [7:0] units_seg
);

  logic [3:0] tens;
  logic [3:0] units;

  always_comb begin
    tens      = 4'(bin_i / 7'd10);
    units     = 4'(bin_i % 7'd10);
    tens_seg  = seg_of_digit(tens);
    units_seg = seg_of_digit(units);
    if (bin_i > 7'd99) begin
      tens_seg  = SEG_DASH;
      units_seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// Scans six time digits onto a multiplexed 7-seg tube bus, snapshotting inputs once per frame.
// Output registered one clk behind digit select/snapshot; free-running, no backpressure.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  hour_count,
  input  logic [6:0]  min_count,
  input  logic [6:0]  sec_count,
  input  logic        is_manual_set,
  output logic [10:0] tube_11bit
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         digit_idx_q, digit_idx_d;
  snap_t              snap_q, snap_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [10:0]        tube_q, tube_d;

  logic [7:0] hour_t_seg, hour_u_seg, min_t_seg, min_u_seg, sec_t_seg, sec_u_seg;
  logic [7:0] seg;
  logic       scan_done;
  logic       frame_wrap;

  seg7_decode u_dec_hour (.bin_i(snap_q.hour), .tens_seg(hour_t_seg), .units_seg(hour_u_seg));
  seg7_decode u_dec_min  (.bin_i(snap_q.min),  .tens_seg(min_t_seg),  .units_seg(min_u_seg));
  seg7_decode u_dec_sec  (.bin_i(snap_q.sec),  .tens_seg(sec_t_seg),  .units_seg(sec_u_seg));

  always_comb begin
    scan_done     = (scan_cnt_q == SCAN_LAST);
    frame_wrap    = scan_done && (digit_idx_q == IDX_SEC_U);
    scan_cnt_d    = scan_done ? '0 : scan_cnt_q + SCAN_W'(1);
    digit_idx_d   = digit_idx_q;
    snap_d        = snap_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (scan_done) begin
      digit_idx_d = (digit_idx_q == IDX_SEC_U) ? 3'd0 : digit_idx_q + 3'd1;
    end

    // Snapshot and blink bookkeeping only move at frame boundaries so a frame never tears
    if (frame_wrap) begin
      snap_d = '{set: is_manual_set, hour: hour_count, min: min_count, sec: sec_count};
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    case (digit_idx_q)
      IDX_HOUR_T: seg = hour_t_seg;
      IDX_HOUR_U: seg = hour_u_seg;
      IDX_MIN_T:  seg = min_t_seg;
      IDX_MIN_U:  seg = min_u_seg;
      IDX_SEC_T:  seg = sec_t_seg;
      IDX_SEC_U:  seg = sec_u_seg;
      default:    seg = SEG_BLANK;
    endcase

    if (digit_idx_q == IDX_HOUR_U || digit_idx_q == IDX_MIN_U) begin
      seg[DP_BIT] = 1'b1;
    end

    if (snap_q.set && blink_phase_q && digit_idx_q <= IDX_MIN_U) begin
      seg = SEG_BLANK;
    end

    tube_d = {digit_idx_q, seg};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q    <= '0;
      digit_idx_q   <= '0;
      snap_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      tube_q        <= '0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      snap_q        <= snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      tube_q        <= tube_d;
    end
  end

  assign tube_11bit = tube_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized bench for clock_display_scan: two instances (hold 4 / blink 2 and hold 1 / blink 1)
// compared every cycle against a frame-arithmetic reference model.
module tb_clock_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  hour_count = '0;
  logic [6:0]  min_count = '0;
  logic [6:0]  sec_count = '0;
  logic        is_manual_set = 1'b0;
  logic [10:0] tube_a;
  logic [10:0] tube_b;

  int n_total = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;
  int ea = 0;
  int eb = 0;
  logic [21:0] snap_a [0:4095];
  logic [21:0] snap_b [0:4095];
  logic [7:0]  seg_tab [0:9];

  clock_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst(rst), .hour_count(hour_count), .min_count(min_count),
    .sec_count(sec_count), .is_manual_set(is_manual_set), .tube_11bit(tube_a));

  clock_display_scan #(.SCAN_DIV(1), .BLINK_FRAMES(1)) dut_b (
    .clk(clk), .rst(rst), .hour_count(hour_count), .min_count(min_count),
    .sec_count(sec_count), .is_manual_set(is_manual_set), .tube_11bit(tube_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Edge e (1-based since reset release) shows the digit active during cycle e-1.
  // Frame f shows the inputs captured at the last edge of frame f-1; blink phase is
  // the number of completed blink periods mod 2.
  function automatic logic [10:0] exp_tube(input int e, input int sd, input int bf,
                                           input logic [21:0] sn);
    int t, f, idx, v;
    logic [7:0] s;
    t   = e - 1;
    f   = t / (6 * sd);
    idx = (t / sd) % 6;
    case (idx / 2)
      0:       v = int'(sn[20:14]);
      1:       v = int'(sn[13:7]);
      default: v = int'(sn[6:0]);
    endcase
    if (v > 99) s = 8'h40;
    else        s = seg_tab[(idx % 2 == 0) ? v / 10 : v % 10];
    if (idx == 1 || idx == 3) s[7] = 1'b1;
    if (sn[21] && ((f / bf) % 2 == 1) && idx < 4) s = 8'h00;
    return {3'(idx), s};
  endfunction

  always @(posedge clk) begin
    if (mon_on) begin
      ea++;
      eb++;
      if (ea % 24 == 0 && ea / 24 < 4096)
        snap_a[ea / 24] = {is_manual_set, hour_count, min_count, sec_count};
      if (eb % 6 == 0 && eb / 6 < 4096)
        snap_b[eb / 6] = {is_manual_set, hour_count, min_count, sec_count};
      #1;
      chk("tube_a", tube_a, exp_tube(ea, 4, 2, snap_a[(ea - 1) / 24]));
      chk("tube_b", tube_b, exp_tube(eb, 1, 1, snap_b[(eb - 1) / 6]));
    end
  end

  task automatic release_reset();
    ea = 0;
    eb = 0;
    snap_a[0] = '0;
    snap_b[0] = '0;
    rst = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    mon_on = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_async_a", tube_a, 11'h000);
    chk("rst_async_b", tube_b, 11'h000);
    repeat (2) @(negedge clk);
    chk("rst_hold_a", tube_a, 11'h000);
    release_reset();
  endtask

  initial begin
    seg_tab[0] = 8'h3F; seg_tab[1] = 8'h06; seg_tab[2] = 8'h5B; seg_tab[3] = 8'h4F;
    seg_tab[4] = 8'h66; seg_tab[5] = 8'h6D; seg_tab[6] = 8'h7D; seg_tab[7] = 8'h07;
    seg_tab[8] = 8'h7F; seg_tab[9] = 8'h6F;

    repeat (3) @(negedge clk);
    chk("reset_state_a", tube_a, 11'h000);
    chk("reset_state_b", tube_b, 11'h000);
    release_reset();

    // Directed: 23:59:07 shown from frame 1; second change mid-frame must wait a frame
    hour_count = 7'd23; min_count = 7'd59; sec_count = 7'd7;
    repeat (34) @(negedge clk);
    sec_count = 7'd8;
    repeat (48) @(negedge clk);
    is_manual_set = 1'b1;
    repeat (8 * 24) @(negedge clk);
    is_manual_set = 1'b0;
    repeat (3 * 24) @(negedge clk);
    sec_count = 7'd100; min_count = 7'd99;
    repeat (3 * 24) @(negedge clk);

    // Reset in the middle of a frame
    repeat (7) @(negedge clk);
    pulse_reset();

    // Randomized inputs, including over-range values and toggling manual set
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       hour_count = 7'($urandom_range(0, 127));
          1:       min_count  = 7'($urandom_range(0, 127));
          default: sec_count  = 7'($urandom_range(0, 127));
        endcase
      end
      if ($urandom_range(0, 63) == 0) is_manual_set = ~is_manual_set;
      if (i == 1000) is_manual_set = 1'b1;
    end

    pulse_reset();
    repeat (30) @(negedge clk);
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
